// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage of the five-stage pipeline.
package fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_LSB = 26;

  localparam logic [5:0]         OP_HALT   = 6'b111111;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALT
  } fetchState_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               imem_req;
  logic [INSTR_W-1:0] imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: holds when not written, a bubble clears instr/valid but keeps pc4.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               writeEn,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [31:0]        pc4In,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc4,
  output logic               valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (writeEn) begin
      if (bubble) begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end else begin
        instr <= instrIn;
        pc4   <= pc4In;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory and writes IF/ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = OP_HALT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_enable,
  input  logic               if_enable,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  fetch_unit_if.master       imem,
  output logic [INSTR_W-1:0] instr_id,
  output logic [31:0]        pc4_id,
  output logic               valid_id,
  output logic               fin,
  output logic               fetch_busy
);

  fetchState_t        state;
  fetchState_t        nextState;
  logic [31:0]        pcQ;
  logic [INSTR_W-1:0] holdBuf;
  logic               dropQ;

  logic               adv;
  logic               liveAck;
  logic               loadWord;
  logic               haltWord;
  logic               ifWrite;
  logic               ifBubble;
  logic [INSTR_W-1:0] wordIn;
  logic [31:0]        pcPlus4;

  // A response only counts when it is not the stale answer to a redirected fetch.
  assign adv      = pc_enable & if_enable;
  assign pcPlus4  = pcQ + 32'd4;
  assign liveAck  = (state == REQ) & imem.imem_ack & ~dropQ;
  assign wordIn   = (state == HOLD) ? holdBuf : imem.imem_rdata;
  assign loadWord = ~redirect & adv & (liveAck | (state == HOLD));
  assign haltWord = loadWord & (wordIn[INSTR_W-1:OPC_LSB] == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = REQ;
      REQ: begin
        if (redirect) begin
          nextState = REQ;
        end else if (haltWord) begin
          nextState = HALT;
        end else if (liveAck && !adv) begin
          nextState = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          nextState = REQ;
        end else if (haltWord) begin
          nextState = HALT;
        end else if (adv) begin
          nextState = REQ;
        end
      end
      HALT:    nextState = HALT;
      default: nextState = IDLE;
    endcase
  end

  // A redirect flushes IF/ID even under a stall; otherwise an empty slot becomes a bubble.
  always_comb begin
    imem.imem_req = 1'b0;
    ifWrite       = 1'b0;
    ifBubble      = 1'b0;
    if (state == REQ || state == HOLD) begin
      imem.imem_req = (state == REQ) & ~dropQ;
      if (redirect) begin
        ifWrite  = 1'b1;
        ifBubble = 1'b1;
      end else if (loadWord) begin
        ifWrite  = 1'b1;
      end else if (if_enable) begin
        ifWrite  = 1'b1;
        ifBubble = 1'b1;
      end
    end
  end

  assign imem.imem_addr = pcQ;
  assign fin            = (state == HALT);
  assign fetch_busy     = (state == REQ) & imem.imem_req & ~imem.imem_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcQ     <= RESET_PC;
      holdBuf <= '0;
      dropQ   <= 1'b0;
    end else if (state == REQ || state == HOLD) begin
      if (redirect) begin
        pcQ   <= redirect_pc;
        dropQ <= (state == REQ) & ~imem.imem_ack;
      end else begin
        if (loadWord) begin
          pcQ <= pcPlus4;
        end
        if (state == REQ && imem.imem_ack) begin
          dropQ <= 1'b0;
        end
        if (liveAck && !adv) begin
          holdBuf <= imem.imem_rdata;
        end
      end
    end
  end

  if_id_reg ifIdReg (
    .clk     (clk),
    .rst_n   (rst_n),
    .writeEn (ifWrite),
    .bubble  (ifBubble),
    .instrIn (wordIn),
    .pc4In   (pcPlus4),
    .instr   (instr_id),
    .pc4     (pc4_id),
    .valid   (valid_id)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stalls, redirects and memory
// latency, each cycle compared against a behavioural fetch-stage model.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_enable;
  logic        if_enable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_id;
  logic [31:0] pc4_id;
  logic        valid_id;
  logic        fin;
  logic        fetch_busy;

  fetch_unit_if imem();

  fetch_unit #(
    .RESET_PC    (RESET_PC),
    .HALT_OPCODE (OP_HALT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_enable   (pc_enable),
    .if_enable   (if_enable),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .instr_id    (instr_id),
    .pc4_id      (pc4_id),
    .valid_id    (valid_id),
    .fin         (fin),
    .fetch_busy  (fetch_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the stage, in terms of what has been fetched rather than FSM states.
  bit          mBooted;
  bit          mHalted;
  bit          mHoldValid;
  bit          mDrop;
  logic [31:0] mPc;
  logic [31:0] mHold;
  logic [31:0] mInstr;
  logic [31:0] mPc4;
  bit          mValid;

  bit          memPending;
  int          memCnt;
  logic [31:0] memAddr;
  int          forceLat = 0;
  logic [31:0] haltAddr = 32'hFFFF_FFFF;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [31:0] w;
    if (addr == haltAddr) return 32'hFC00_0000;
    w = (addr * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    if (w[31:26] == OP_HALT) w[31] = 1'b0;
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mBooted    = 1'b0;
    mHalted    = 1'b0;
    mHoldValid = 1'b0;
    mDrop      = 1'b0;
    mPc        = RESET_PC;
    mHold      = '0;
    mInstr     = '0;
    mPc4       = '0;
    mValid     = 1'b0;
    memPending = 1'b0;
    memCnt     = 0;
  endtask

  task automatic modelBubble();
    mInstr = '0;
    mValid = 1'b0;
  endtask

  task automatic modelLoad(input logic [31:0] w);
    mInstr = w;
    mPc4   = mPc + 32'd4;
    mValid = 1'b1;
    mPc    = mPc + 32'd4;
    if (w[31:26] == OP_HALT) mHalted = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model, clock.
  task automatic applyStimulus(input bit rstN, input bit pe, input bit ie,
                               input bit rd, input logic [31:0] rpc);
    bit          ack;
    bit          expReq;
    logic [31:0] rdata;
    int          newLat;
    expReq = mBooted && !mHalted && !mHoldValid && !mDrop;
    if (forceLat >= 0) newLat = forceLat;
    else newLat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    ack   = 1'b0;
    rdata = $urandom;
    if (memPending) begin
      ack = (memCnt == 0);
      if (ack) rdata = memWord(memAddr);
    end else if (expReq && newLat == 0) begin
      ack   = 1'b1;
      rdata = memWord(mPc);
    end
    rst_n            = rstN;
    pc_enable        = pe;
    if_enable        = ie;
    redirect         = rd;
    redirect_pc      = rpc;
    imem.imem_ack    = ack;
    imem.imem_rdata  = rdata;
    #1;
    checkOutput("imem_req", imem.imem_req, expReq);
    if (expReq || !mBooted) checkOutput("imem_addr", imem.imem_addr, mPc);
    checkOutput("instr_id", instr_id, mInstr);
    checkOutput("pc4_id", pc4_id, mPc4);
    checkOutput("valid_id", valid_id, mValid);
    checkOutput("fin", fin, mHalted);
    checkOutput("fetch_busy", fetch_busy, expReq && !ack);

    if (!rstN) begin
      modelReset();
    end else begin
      if (memPending) begin
        if (memCnt == 0) memPending = 1'b0;
        else memCnt--;
      end else if (expReq && newLat != 0) begin
        memPending = 1'b1;
        memCnt     = newLat - 1;
        memAddr    = mPc;
      end
      if (!mBooted) begin
        mBooted = 1'b1;
      end else if (mHalted) begin
        mBooted = 1'b1;
      end else if (mHoldValid) begin
        if (rd) begin
          mPc = rpc;
          mHoldValid = 1'b0;
          modelBubble();
        end else if (pe && ie) begin
          mHoldValid = 1'b0;
          modelLoad(mHold);
        end else if (ie) begin
          modelBubble();
        end
      end else begin
        if (rd) begin
          mPc   = rpc;
          mDrop = !ack;
          modelBubble();
        end else if (ack && mDrop) begin
          mDrop = 1'b0;
          if (ie) modelBubble();
        end else if (ack && pe && ie) begin
          modelLoad(rdata);
        end else if (ack) begin
          mHold      = rdata;
          mHoldValid = 1'b1;
          if (ie) modelBubble();
        end else if (ie) begin
          modelBubble();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] rnd;
    bit          stall;
    rst_n           = 1'b0;
    pc_enable       = 1'b0;
    if_enable       = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    checkOutput("rst_req", imem.imem_req, 1'b0);
    checkOutput("rst_addr", imem.imem_addr, RESET_PC);
    checkOutput("rst_instr", instr_id, 32'h0);
    checkOutput("rst_pc4", pc4_id, 32'h0);
    checkOutput("rst_valid", valid_id, 1'b0);
    checkOutput("rst_fin", fin, 1'b0);
    checkOutput("rst_busy", fetch_busy, 1'b0);

    stream(2);
    checkOutput("zw_pc4", pc4_id, 32'h4);
    checkOutput("zw_instr", instr_id, memWord(32'h0));
    checkOutput("zw_addr", imem.imem_addr, 32'h4);
    stream(3);

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("hold_req", imem.imem_req, 1'b0);
    checkOutput("hold_pc4", pc4_id, 32'h10);
    stream(1);
    checkOutput("rel_pc4", pc4_id, 32'h14);
    checkOutput("rel_instr", instr_id, memWord(32'h10));
    checkOutput("rel_addr", imem.imem_addr, 32'h14);
    checkOutput("rel_req", imem.imem_req, 1'b1);
    stream(3);

    forceLat = 2;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
    checkOutput("redir_valid", valid_id, 1'b0);
    checkOutput("redir_req", imem.imem_req, 1'b0);
    stream(1);
    checkOutput("drop_req", imem.imem_req, 1'b1);
    checkOutput("drop_addr", imem.imem_addr, 32'h100);
    forceLat = 0;
    stream(1);
    checkOutput("tgt_pc4", pc4_id, 32'h104);
    checkOutput("tgt_valid", valid_id, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
    checkOutput("ackredir_valid", valid_id, 1'b0);
    checkOutput("ackredir_addr", imem.imem_addr, 32'h200);
    checkOutput("ackredir_pc4", pc4_id, 32'h104);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    stream(2);
    checkOutput("wrap_pc4", pc4_id, 32'h0);
    checkOutput("wrap_addr", imem.imem_addr, 32'h0);

    forceLat = -1;
    for (int i = 0; i < 400; i++) begin
      rnd   = $urandom;
      stall = ($urandom_range(0, 3) == 0);
      applyStimulus(($urandom_range(0, 79) != 0), !stall, !stall,
                    ($urandom_range(0, 9) == 0), {rnd[31:2], 2'b00});
    end

    forceLat = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    haltAddr = 32'h40;
    for (int i = 0; i < 40 && !mHalted; i++) stream(1);
    checkOutput("halt_fin", fin, 1'b1);
    checkOutput("halt_instr", instr_id, 32'hFC00_0000);
    checkOutput("halt_req", imem.imem_req, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
    checkOutput("frozen_fin", fin, 1'b1);
    checkOutput("frozen_instr", instr_id, 32'hFC00_0000);
    checkOutput("frozen_req", imem.imem_req, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    haltAddr = 32'hFFFF_FFFF;
    stream(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rhold_instr", instr_id, 32'h0);
    checkOutput("rhold_pc4", pc4_id, 32'h0);
    checkOutput("rhold_valid", valid_id, 1'b0);
    checkOutput("rhold_fin", fin, 1'b0);
    checkOutput("rhold_req", imem.imem_req, 1'b0);
    checkOutput("rhold_addr", imem.imem_addr, RESET_PC);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("restart_req", imem.imem_req, 1'b1);
    checkOutput("restart_addr", imem.imem_addr, RESET_PC);
    stream(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
